// File: rtl/gate_chk_pkg.sv
// Shared types for the two-input gate checkers.
// Op encodings, FSM states and op validation.
package gate_chk_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic is_valid_op(
    input logic [OP_W-1:0] op
  );
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the two-input gate library.
// Reserved ops produce 0.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_NAND: expected = ~(a & b);
      OP_NOR:  expected = ~(a | b);
      OP_XOR:  expected = a ^ b;
      OP_XNOR: expected = ~(a ^ b);
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks a 2-input gate through its truth table and
// compares c against the reference, keeping statistics.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op_sel,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             bad_op,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [3:0]       fail_vec
);

  localparam int SC_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PI_W =
    (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PI_W-1:0] PI_LAST =
    PI_W'(REPEAT - 1);

  state_e           state;
  state_e           state_d;
  logic [OP_W-1:0]  op_q;
  logic [1:0]       vec;
  logic [PI_W-1:0]  pass_idx;
  logic [SC_W-1:0]  settle_cnt;
  logic             expected;
  logic             accept;
  logic             op_ok;
  logic             sample;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] err_cnt_d;

  gate_ref_model u_ref (
    .op       (op_q),
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE, ST_DONE:
        if (start) state_d = op_ok ? ST_RUN : ST_DONE;
      ST_RUN:
        if (sample && last_vec) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state != ST_RUN) && start;
    op_ok     = is_valid_op(op_sel);
    sample    = (state == ST_RUN) && (settle_cnt == SC_LAST);
    mismatch  = sample && (c != expected);
    last_vec  = (vec == 2'd3) && (pass_idx == PI_LAST);
    err_cnt_d = err_cnt;
    if (mismatch && !(&err_cnt))
      err_cnt_d = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      vec        <= '0;
      pass_idx   <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      bad_op     <= 1'b0;
      err_cnt    <= '0;
      vec_cnt    <= '0;
      fail_vec   <= '0;
    end else if (accept) begin
      op_q       <= op_sel;
      vec        <= '0;
      pass_idx   <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      err_cnt    <= '0;
      vec_cnt    <= '0;
      fail_vec   <= '0;
      pass       <= 1'b0;
      busy       <= op_ok;
      done       <= !op_ok;
      bad_op     <= !op_ok;
    end else if (state == ST_RUN) begin
      settle_cnt <= settle_cnt + 1'b1;
      if (sample) begin
        settle_cnt <= '0;
        err_cnt    <= err_cnt_d;
        if (mismatch) fail_vec[vec] <= 1'b1;
        if (!(&vec_cnt)) vec_cnt <= vec_cnt + 1'b1;
        if (vec != 2'd3) begin
          vec    <= vec + 2'd1;
          {a, b} <= vec + 2'd1;
        end else if (!last_vec) begin
          vec      <= '0;
          pass_idx <= pass_idx + 1'b1;
          {a, b}   <= 2'b00;
        end else begin
          {a, b} <= 2'b00;
          busy   <= 1'b0;
          done   <= 1'b1;
          pass   <= (err_cnt_d == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench: two checker instances driving a behavioural or_gate
// or a stuck-at-1 output; results checked via a scoreboard.
module tb_gate_truth_table_checker;

  localparam int S = 2;

  typedef struct packed {
    logic [7:0] err;
    logic [7:0] vec;
    logic [3:0] fv;
    logic       pass;
    logic       bad;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0;
  logic [2:0] op1 = 3'd0;
  logic       stuck1 = 1'b0;
  logic       a1, b1, c1, busy1, done1, pass1, bad1;
  logic [7:0] err1, vcnt1;
  logic [3:0] fv1;

  logic       start3 = 1'b0;
  logic [2:0] op3 = 3'd0;
  logic       stuck3 = 1'b0;
  logic       a3, b3, c3, busy3, done3, pass3, bad3;
  logic [7:0] err3, vcnt3;
  logic [3:0] fv3;

  assign c1 = stuck1 ? 1'b1 : (a1 | b1);
  assign c3 = stuck3 ? 1'b1 : (a3 | b3);

  gate_truth_table_checker #(
    .SETTLE_CYCLES (S), .REPEAT (1), .CNT_W (8)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start1),
    .op_sel (op1), .a (a1), .b (b1), .c (c1),
    .busy (busy1), .done (done1), .pass (pass1),
    .bad_op (bad1), .err_cnt (err1), .vec_cnt (vcnt1),
    .fail_vec (fv1)
  );

  gate_truth_table_checker #(
    .SETTLE_CYCLES (S), .REPEAT (3), .CNT_W (8)
  ) dut3 (
    .clk (clk), .rst_n (rst_n), .start (start3),
    .op_sel (op3), .a (a3), .b (b3), .c (c3),
    .busy (busy3), .done (done3), .pass (pass3),
    .bad_op (bad3), .err_cnt (err3), .vec_cnt (vcnt3),
    .fail_vec (fv3)
  );

  res_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic ref_fn(
    input logic [2:0] op, input logic [1:0] v
  );
    logic [3:0] tt;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0111;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    return tt[v];
  endfunction

  function automatic res_t model(
    input logic [2:0] op, input logic stuck, input int reps
  );
    res_t r;
    logic [1:0] v;
    logic cv;
    r = '0;
    if (op > 3'd5) begin
      r.bad = 1'b1;
      return r;
    end
    for (int p = 0; p < reps; p++)
      for (int k = 0; k < 4; k++) begin
        v  = 2'(k);
        cv = stuck ? 1'b1 : (v[1] | v[0]);
        if (cv != ref_fn(op, v)) begin
          r.err   = r.err + 8'd1;
          r.fv[k] = 1'b1;
        end
        r.vec = r.vec + 8'd1;
      end
    r.pass = (r.err == 8'd0);
    return r;
  endfunction

  function automatic res_t obs(input int sel);
    if (sel == 1) return {err1, vcnt1, fv1, pass1, bad1};
    return {err3, vcnt3, fv3, pass3, bad3};
  endfunction

  task automatic pulse(input int sel, input logic [2:0] op);
    @(negedge clk);
    if (sel == 1) begin op1 = op; start1 = 1'b1; end
    else begin op3 = op; start3 = 1'b1; end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(
    input int sel, input int max, output int cyc
  );
    cyc = 0;
    while (((sel == 1) ? !done1 : !done3) && cyc < max) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (obs(1) !== res_t'(0)) begin
      n_bad++;
      $display("FAIL reset_stats1 got %h want 0", obs(1));
    end
    n_cmp++;
    if ({a1, b1, busy1, done1} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctl1 got %b want 0000",
               {a1, b1, busy1, done1});
    end
    n_cmp++;
    if (obs(3) !== res_t'(0)) begin
      n_bad++;
      $display("FAIL reset_stats3 got %h want 0", obs(3));
    end
    n_cmp++;
    if ({a3, b3, busy3, done3} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctl3 got %b want 0000",
               {a3, b3, busy3, done3});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_or_pass;
    logic [1:0] exp_ab;
    res_t e;
    stuck1 = 1'b0;
    sb.push_back(model(3'd1, 1'b0, 1));
    pulse(1, 3'd1);
    for (int k = 0; k < 4 * S; k++) begin
      exp_ab = 2'(k / S);
      n_cmp++;
      if ({a1, b1, busy1, done1} !== {exp_ab, 2'b10}) begin
        n_bad++;
        $display("FAIL or_seq cyc=%0d got %b want %b", k,
                 {a1, b1, busy1, done1}, {exp_ab, 2'b10});
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({a1, b1, busy1, done1} !== 4'b0001) begin
      n_bad++;
      $display("FAIL or_end got %b want 0001",
               {a1, b1, busy1, done1});
    end
    e = sb.pop_front();
    n_cmp++;
    if (obs(1) !== e) begin
      n_bad++;
      $display("FAIL or_stats got %h want %h", obs(1), e);
    end
  endtask

  task automatic test_and_mismatch;
    int cyc;
    res_t e;
    sb.push_back(model(3'd0, 1'b0, 1));
    pulse(1, 3'd0);
    wait_done(1, 40, cyc);
    n_cmp++;
    if (cyc !== 4 * S) begin
      n_bad++;
      $display("FAIL and_latency got %0d want %0d", cyc, 4 * S);
    end
    e = sb.pop_front();
    n_cmp++;
    if (obs(1) !== e) begin
      n_bad++;
      $display("FAIL and_stats got %h want %h", obs(1), e);
    end
  endtask

  task automatic test_repeat_stuck;
    int cyc;
    res_t e;
    stuck3 = 1'b1;
    sb.push_back(model(3'd1, 1'b1, 3));
    pulse(3, 3'd1);
    wait_done(3, 80, cyc);
    n_cmp++;
    if (cyc !== 12 * S) begin
      n_bad++;
      $display("FAIL rep_latency got %0d want %0d", cyc, 12 * S);
    end
    e = sb.pop_front();
    n_cmp++;
    if (obs(3) !== e) begin
      n_bad++;
      $display("FAIL rep_stats got %h want %h", obs(3), e);
    end
    stuck3 = 1'b0;
  endtask

  task automatic test_bad_op;
    res_t e;
    sb.push_back(model(3'd6, 1'b0, 1));
    pulse(1, 3'd6);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({a1, b1, busy1, done1} !== 4'b0001) begin
        n_bad++;
        $display("FAIL badop_ctl cyc=%0d got %b want 0001", k,
                 {a1, b1, busy1, done1});
      end
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    n_cmp++;
    if (obs(1) !== e) begin
      n_bad++;
      $display("FAIL badop_stats got %h want %h", obs(1), e);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    res_t e;
    pulse(1, 3'd1);
    repeat (2 * S) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({a1, b1, busy1} !== 3'b101) begin
      n_bad++;
      $display("FAIL mid_vec2 got %b want 101", {a1, b1, busy1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a1, b1, busy1, done1, obs(1)} !== '0) begin
      n_bad++;
      $display("FAIL mid_async_rst got %b %h want 0",
               {a1, b1, busy1, done1}, obs(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(3'd1, 1'b0, 1));
    pulse(1, 3'd1);
    n_cmp++;
    if ({a1, b1, busy1, done1} !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_restart got %b want 0010",
               {a1, b1, busy1, done1});
    end
    wait_done(1, 40, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== 4 * S || obs(1) !== e) begin
      n_bad++;
      $display("FAIL mid_rerun got cyc=%0d %h want cyc=%0d %h",
               cyc, obs(1), 4 * S, e);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    res_t e;
    sb.push_back(model(3'd4, 1'b0, 1));
    pulse(1, 3'd4);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    pulse(1, 3'd0);
    wait_done(1, 40, cyc);
    n_cmp++;
    if (cyc !== 4 * S - 4) begin
      n_bad++;
      $display("FAIL b2b_latency got %0d want %0d",
               cyc, 4 * S - 4);
    end
    e = sb.pop_front();
    n_cmp++;
    if (obs(1) !== e) begin
      n_bad++;
      $display("FAIL b2b_ignore got %h want %h", obs(1), e);
    end
    sb.push_back(model(3'd1, 1'b0, 1));
    pulse(1, 3'd1);
    n_cmp++;
    if ({busy1, done1, err1, vcnt1, fv1} !== 22'b10 << 20) begin
      n_bad++;
      $display("FAIL b2b_clear got %b %h %h %b want busy=1 0s",
               {busy1, done1}, err1, vcnt1, fv1);
    end
    wait_done(1, 40, cyc);
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== 4 * S || obs(1) !== e) begin
      n_bad++;
      $display("FAIL b2b_fresh got cyc=%0d %h want cyc=%0d %h",
               cyc, obs(1), 4 * S, e);
    end
  endtask

  initial begin
    test_reset();
    test_or_pass();
    test_and_mismatch();
    test_repeat_stuck();
    test_bad_op();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
